// File: rtl/risc_run_ctrl_if.sv
// risc_run_ctrl_if: control/status bundle between the run controller and its environment.
// With RUN_SIG_EN defined the bundle also carries the MISR signature.
interface risc_run_ctrl_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 32
`ifdef RUN_SIG_EN
  ,
  parameter int SIG_W = 16
`endif
);
  logic             start;
  logic             abort;
  logic             halt;
  logic [PC_W-1:0]  pc;
  logic             core_rst_n;
  logic             core_en;
  logic             busy;
  logic [CNT_W-1:0] cycle_cnt;
  logic             done;
  logic             timeout;
  logic             stalled;
`ifdef RUN_SIG_EN
  logic [SIG_W-1:0] signature;
`endif

  // Environment side: requests runs and reflects core status.
  modport master (
    output start, abort, halt, pc,
    input  core_rst_n, core_en, busy, cycle_cnt, done, timeout, stalled
`ifdef RUN_SIG_EN
    , input signature
`endif
  );

  // Controller side.
  modport slave (
    input  start, abort, halt, pc,
    output core_rst_n, core_en, busy, cycle_cnt, done, timeout, stalled
`ifdef RUN_SIG_EN
    , output signature
`endif
  );
endinterface

// File: rtl/risc_run_ctrl.sv
// risc_run_ctrl: sequences a RISC core through reset hold, run and stop.
// Holds the core in reset for RST_CYCLES after start, counts RUN cycles, and ends the
// run on abort, halt, PC stall or timeout, reporting the cause. All outputs registered.
// Optional feature macro RUN_SIG_EN: builds a Fibonacci MISR over the PC trace and
// exposes it on the signature port; without it no MISR logic exists.
module risc_run_ctrl #(
  parameter int PC_W         = 16,
  parameter int CNT_W        = 32,
  parameter int RST_CYCLES   = 4,
  parameter int MAX_CYCLES   = 1000,
  parameter int STALL_CYCLES = 8
`ifdef RUN_SIG_EN
  ,
  parameter int SIG_W        = 16
`endif
) (
  input logic            clk,
  input logic            rst_n,
  risc_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RST_HOLD, RUN, DONE} state_t;

  localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W:0]     MAX_LIM    = (CNT_W + 1)'(MAX_CYCLES);

`ifdef RUN_SIG_EN
  // Default width uses x^16+x^12+x^5+1 (stages 16,12,5); other widths fall back to a two-tap form.
  localparam logic [SIG_W-1:0] SIG_TAPS = (SIG_W == 16) ? SIG_W'(32'h0000_8810)
                                                       : SIG_W'((32'h1 << (SIG_W - 1)) | 32'h1);
`endif

  state_t             state, state_nx;
  logic [HOLD_W-1:0]  hold_cnt, hold_nx;
  logic [STALL_W-1:0] stall_cnt, stall_nx;
  logic [PC_W-1:0]    prev_pc, prev_pc_nx;
  logic               prev_valid, prev_valid_nx;
  logic [CNT_W-1:0]   cycle_cnt, cycle_nx;
  logic               core_rst_n_q, core_rst_n_nx;
  logic               core_en_q, core_en_nx;
  logic               busy_q, busy_nx;
  logic               done_q, done_nx;
  logic               timeout_q, timeout_nx;
  logic               stalled_q, stalled_nx;
  logic               to_idle, to_hold, to_done;
`ifdef RUN_SIG_EN
  logic [SIG_W-1:0]   sig_q, sig_nx;
`endif

  logic               pc_same;
  logic               stall_hit;
  logic               time_hit;
  logic [CNT_W:0]     cnt_plus;
  logic [CNT_W-1:0]   cycle_sat;

  // prev_valid masks the first RUN cycle, whose prev_pc is left over from an earlier run.
  assign pc_same   = prev_valid && (bus.pc == prev_pc);
  assign stall_hit = pc_same && (stall_cnt == STALL_LAST);
  assign cnt_plus  = {1'b0, cycle_cnt} + 1'b1;
  assign time_hit  = (MAX_CYCLES != 0) && (cnt_plus == MAX_LIM);
  assign cycle_sat = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;

  // Next-state and next-output decode; abort outranks everything, then halt, stall, timeout.
  always_comb begin
    state_nx      = state;
    hold_nx       = hold_cnt;
    stall_nx      = stall_cnt;
    prev_pc_nx    = prev_pc;
    prev_valid_nx = prev_valid;
    cycle_nx      = cycle_cnt;
    core_rst_n_nx = core_rst_n_q;
    core_en_nx    = core_en_q;
    busy_nx       = busy_q;
    done_nx       = done_q;
    timeout_nx    = timeout_q;
    stalled_nx    = stalled_q;
    to_idle       = 1'b0;
    to_hold       = 1'b0;
    to_done       = 1'b0;
`ifdef RUN_SIG_EN
    sig_nx        = sig_q;
`endif

    unique case (state)
      IDLE, DONE: begin
        if (bus.abort)      to_idle = 1'b1;
        else if (bus.start) to_hold = 1'b1;
      end
      RST_HOLD: begin
        if (bus.abort) begin
          to_idle = 1'b1;
        end else if (hold_cnt == '0) begin
          state_nx      = RUN;
          core_rst_n_nx = 1'b1;
          core_en_nx    = 1'b1;
          prev_valid_nx = 1'b0;
          stall_nx      = '0;
        end else begin
          hold_nx = hold_cnt - 1'b1;
        end
      end
      RUN: begin
        cycle_nx      = cycle_sat;
        prev_pc_nx    = bus.pc;
        prev_valid_nx = 1'b1;
        stall_nx      = pc_same ? stall_cnt + 1'b1 : '0;
`ifdef RUN_SIG_EN
        sig_nx = {sig_q[SIG_W-2:0], ^(sig_q & SIG_TAPS)} ^ bus.pc[SIG_W-1:0];
`endif
        if (bus.abort) begin
          to_idle = 1'b1;
        end else if (bus.halt) begin
          to_done = 1'b1;
        end else if (stall_hit) begin
          to_done    = 1'b1;
          stalled_nx = 1'b1;
        end else if (time_hit) begin
          to_done    = 1'b1;
          timeout_nx = 1'b1;
        end
      end
      default: to_idle = 1'b1;
    endcase

    if (to_done) begin
      state_nx   = DONE;
      core_en_nx = 1'b0;
      busy_nx    = 1'b0;
      done_nx    = 1'b1;
    end

    if (to_idle) begin
      state_nx      = IDLE;
      core_rst_n_nx = 1'b0;
      core_en_nx    = 1'b0;
      busy_nx       = 1'b0;
      done_nx       = 1'b0;
      timeout_nx    = 1'b0;
      stalled_nx    = 1'b0;
    end

    if (to_hold) begin
      state_nx      = RST_HOLD;
      hold_nx       = HOLD_LOAD;
      core_rst_n_nx = 1'b0;
      core_en_nx    = 1'b0;
      busy_nx       = 1'b1;
      cycle_nx      = '0;
      done_nx       = 1'b0;
      timeout_nx    = 1'b0;
      stalled_nx    = 1'b0;
`ifdef RUN_SIG_EN
      sig_nx        = '0;
`endif
    end
  end

  // State and registered outputs; rst_n clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      stall_cnt    <= '0;
      prev_pc      <= '0;
      prev_valid   <= 1'b0;
      cycle_cnt    <= '0;
      core_rst_n_q <= 1'b0;
      core_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      stalled_q    <= 1'b0;
`ifdef RUN_SIG_EN
      sig_q        <= '0;
`endif
    end else begin
      state        <= state_nx;
      hold_cnt     <= hold_nx;
      stall_cnt    <= stall_nx;
      prev_pc      <= prev_pc_nx;
      prev_valid   <= prev_valid_nx;
      cycle_cnt    <= cycle_nx;
      core_rst_n_q <= core_rst_n_nx;
      core_en_q    <= core_en_nx;
      busy_q       <= busy_nx;
      done_q       <= done_nx;
      timeout_q    <= timeout_nx;
      stalled_q    <= stalled_nx;
`ifdef RUN_SIG_EN
      sig_q        <= sig_nx;
`endif
    end
  end

  assign bus.core_rst_n = core_rst_n_q;
  assign bus.core_en    = core_en_q;
  assign bus.busy       = busy_q;
  assign bus.cycle_cnt  = cycle_cnt;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.stalled    = stalled_q;
`ifdef RUN_SIG_EN
  assign bus.signature  = sig_q;
`endif

endmodule

// File: tb/tb_risc_run_ctrl.sv
// tb_risc_run_ctrl: directed, table-driven bench for risc_run_ctrl (default parameters).
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_risc_run_ctrl;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  risc_run_ctrl_if #(.PC_W(16), .CNT_W(32)
`ifdef RUN_SIG_EN
    , .SIG_W(16)
`endif
  ) bus ();

  risc_run_ctrl #(
    .PC_W(16), .CNT_W(32), .RST_CYCLES(4), .MAX_CYCLES(1000), .STALL_CYCLES(8)
`ifdef RUN_SIG_EN
    , .SIG_W(16)
`endif
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // One run: pc(k)=k until cycle 'freeze', then stays at 'freeze'; events fire on RUN cycle k.
  typedef struct {
    int   freeze;
    int   halt_at;
    int   abort_at;
    int   start_at;
    logic exp_done;
    logic exp_timeout;
    logic exp_stalled;
    logic exp_rst_n;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse start, confirm the counter was cleared, then wait (bounded) for RUN.
  task automatic startRun();
    int guard;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("clearedCnt", bus.cycle_cnt, 32'd0);
    guard = 0;
    while (!bus.core_en && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("enterRun", {31'd0, bus.core_en}, 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input int bias, output int cycles);
    int k;
    int val;
    startRun();
    k = 0;
    while (bus.busy && k < 1100) begin
      k++;
      val       = (v.freeze != 0 && k > v.freeze) ? v.freeze : k;
      bus.pc    = 16'(val + bias);
      bus.halt  = (k == v.halt_at);
      bus.abort = (k == v.abort_at);
      bus.start = (k == v.start_at);
      @(negedge clk);
    end
    bus.halt  = 1'b0;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    cycles    = k;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".core_rst_n"}, {31'd0, bus.core_rst_n}, 32'd0);
    checkOutput({tag, ".core_en"},    {31'd0, bus.core_en},    32'd0);
    checkOutput({tag, ".busy"},       {31'd0, bus.busy},       32'd0);
    checkOutput({tag, ".cycle_cnt"},  bus.cycle_cnt,           32'd0);
    checkOutput({tag, ".done"},       {31'd0, bus.done},       32'd0);
    checkOutput({tag, ".timeout"},    {31'd0, bus.timeout},    32'd0);
    checkOutput({tag, ".stalled"},    {31'd0, bus.stalled},    32'd0);
`ifdef RUN_SIG_EN
    checkOutput({tag, ".signature"},  {16'd0, bus.signature},  32'd0);
`endif
  endtask

`ifdef RUN_SIG_EN
  function automatic logic [15:0] misrModel(input int n, input int bias);
    logic [15:0] s;
    logic        fb;
    s = '0;
    for (int k = 1; k <= n; k++) begin
      fb = s[15] ^ s[11] ^ s[4];
      s  = {s[14:0], fb} ^ 16'(k + bias);
    end
    return s;
  endfunction
`endif

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cycles;
    int   hold;
    vec_t v;

    compared   = 0;
    mismatched = 0;

    //        freeze halt abort start  done to st rst_n  cnt
    vecs[0] = '{0,    0,    0,    0,   1'b1, 1'b1, 1'b0, 1'b1, 1000};
    vecs[1] = '{20,   0,    0,    0,   1'b1, 1'b0, 1'b1, 1'b1, 28};
    vecs[2] = '{42,   50,   0,    0,   1'b1, 1'b0, 1'b0, 1'b1, 50};
    vecs[3] = '{0,    0,    10,   0,   1'b0, 1'b0, 1'b0, 1'b0, 10};
    vecs[4] = '{0,    5,    0,    3,   1'b1, 1'b0, 1'b0, 1'b1, 5};
    vecs[5] = '{0,    1,    0,    0,   1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[6] = '{1,    0,    0,    0,   1'b1, 1'b0, 1'b1, 1'b1, 9};
    vecs[7] = '{0,    1000, 0,    0,   1'b1, 1'b0, 1'b0, 1'b1, 1000};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.halt  = 1'b0;
    bus.pc    = '0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset hold length, then abort on the very first RUN cycle.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hold = 0;
    while (!bus.core_rst_n && bus.busy && hold < 20) begin
      hold++;
      @(negedge clk);
    end
    checkOutput("holdCycles", hold, 32'd4);
    checkOutput("holdEndCoreEn", {31'd0, bus.core_en}, 32'd1);
    checkOutput("holdEndBusy", {31'd0, bus.busy}, 32'd1);
    bus.abort = 1'b1;
    bus.pc    = 16'h0100;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort1.busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort1.core_rst_n", {31'd0, bus.core_rst_n}, 32'd0);
    checkOutput("abort1.cycle_cnt", bus.cycle_cnt, 32'd1);
    checkOutput("abort1.done", {31'd0, bus.done}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      applyStimulus(v, 0, cycles);
      checkOutput($sformatf("vec%0d.cycles", i),     cycles,                     v.exp_cnt);
      checkOutput($sformatf("vec%0d.done", i),       {31'd0, bus.done},          {31'd0, v.exp_done});
      checkOutput($sformatf("vec%0d.timeout", i),    {31'd0, bus.timeout},       {31'd0, v.exp_timeout});
      checkOutput($sformatf("vec%0d.stalled", i),    {31'd0, bus.stalled},       {31'd0, v.exp_stalled});
      checkOutput($sformatf("vec%0d.cycle_cnt", i),  bus.cycle_cnt,              v.exp_cnt);
      checkOutput($sformatf("vec%0d.core_rst_n", i), {31'd0, bus.core_rst_n},    {31'd0, v.exp_rst_n});
      checkOutput($sformatf("vec%0d.core_en", i),    {31'd0, bus.core_en},       32'd0);
      checkOutput($sformatf("vec%0d.busy", i),       {31'd0, bus.busy},          32'd0);
    end

    // DONE is held for a few idle cycles.
    repeat (3) @(negedge clk);
    checkOutput("doneHeld.done", {31'd0, bus.done}, 32'd1);
    checkOutput("doneHeld.cycle_cnt", bus.cycle_cnt, 32'd1000);

    // start together with abort in DONE: abort wins, counter kept.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("startAbort.busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("startAbort.done", {31'd0, bus.done}, 32'd0);
    checkOutput("startAbort.core_rst_n", {31'd0, bus.core_rst_n}, 32'd0);
    checkOutput("startAbort.cycle_cnt", bus.cycle_cnt, 32'd1000);

    // abort during reset hold.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("holdAbort.busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("holdAbort.core_rst_n", {31'd0, bus.core_rst_n}, 32'd0);
    checkOutput("holdAbort.core_en", {31'd0, bus.core_en}, 32'd0);

    // Asynchronous reset between clock edges in the middle of a run.
    startRun();
    for (int k = 1; k <= 5; k++) begin
      bus.pc = 16'(k);
      @(negedge clk);
    end
    checkOutput("midRun.cycle_cnt", bus.cycle_cnt, 32'd5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("asyncReset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("afterReset.busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("afterReset.core_rst_n", {31'd0, bus.core_rst_n}, 32'd0);

`ifdef RUN_SIG_EN
    // pc 0..9 with halt on the tenth RUN cycle, twice.
    v = '{0, 10, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 10};
    for (int r = 0; r < 2; r++) begin
      applyStimulus(v, -1, cycles);
      checkOutput($sformatf("sig%0d.cycle_cnt", r), bus.cycle_cnt, 32'd10);
      checkOutput($sformatf("sig%0d.signature", r), {16'd0, bus.signature}, {16'd0, misrModel(10, -1)});
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
